// File: rtl/microwave_pkg.sv
// ---------------------------------------------------------------------------
// microwave_pkg
// Shared definitions for the microwave sequencing controller:
//   - state encoding (3-bit codes visible on state_o)
//   - keypad digit limit
//   - default timing/entry constants used as parameter defaults
// ---------------------------------------------------------------------------
package microwave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    localparam int DEF_TICK_DIV   = 50_000_000;
    localparam int DEF_BEEP_SECS  = 3;
    localparam int DEF_MAX_DIGITS = 3;

    // Keypad codes above 9 are function keys or noise, never timer digits.
    function automatic logic is_digit(input logic [3:0] d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/microwave_ctrl_tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a one-cycle tick every DIV cycles.
//   clock  : system clock, rising edge
//   clearn : asynchronous active-low reset
//   run    : count enable; when low the counter is held at 0
//   clr    : synchronous clear, wins over run; suppresses the tick
//   tick   : one-cycle pulse in the cycle the counter sits at DIV-1
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic clearn,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_reg;

    // A clear in the same cycle as terminal count swallows the tick, so a
    // state change never produces a stray decrement or beep step.
    assign tick = run && !clr && (count_reg == TERM);

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            count_reg <= '0;
        end else if (!run || clr || (count_reg == TERM)) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/microwave_ctrl.sv
// ---------------------------------------------------------------------------
// microwave_ctrl
// Sequencing controller between the front panel and the M:SS countdown
// timer (mod10/mod6/mod10 chain). Shifts keypad digits into the timer,
// runs the 1 s decrement tick while cooking, gates the magnetron and sounds
// the finish beep.
//   clock        : system clock, rising edge
//   clearn       : asynchronous active-low reset
//   key_valid    : one-cycle strobe qualifying key_data
//   key_data     : keypad code, 0-9 are digits
//   start, stop  : level requests, sampled every cycle (stop wins)
//   door_closed  : 1 = door closed
//   timer_zero   : timer reads 0:00
//   timer_clearn : active-low clear to the timer (follows reset too)
//   timer_loadn  : active-low one-cycle shift/load strobe to the timer
//   timer_data   : digit presented with timer_loadn
//   timer_enable : one-cycle decrement pulse to the timer
//   mag_on       : magnetron enable
//   beep         : done indicator
//   state_o      : current state code
// All outputs except timer_clearn are registered.
// ---------------------------------------------------------------------------
module microwave_ctrl
    import microwave_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int BEEP_SECS  = DEF_BEEP_SECS,
    parameter int MAX_DIGITS = DEF_MAX_DIGITS
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic       timer_clearn,
    output logic       timer_loadn,
    output logic [3:0] timer_data,
    output logic       timer_enable,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state_o
);

    localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
    localparam int BEEP_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

    localparam logic [DCNT_W-1:0] DCNT_MAX  = DCNT_W'(MAX_DIGITS);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SECS - 1);

    state_t              state_reg;
    logic [DCNT_W-1:0]   digit_cnt_reg;
    logic [BEEP_W-1:0]   beep_cnt_reg;
    logic                timer_loadn_reg;
    logic [3:0]          timer_data_reg;
    logic                timer_enable_reg;
    logic                mag_on_reg;
    logic                beep_reg;
    logic                clr_pulse_reg;

    logic                key_ok;
    logic                prescale_run;
    logic                prescale_clr;
    logic                tick;

    assign key_ok = key_valid && is_digit(key_data) && (digit_cnt_reg < DCNT_MAX);

    // The prescaler only runs while cooking or beeping. It must read 0 in
    // the first cycle of every state, so the exits that happen off terminal
    // count (cook -> pause/done, done aborted) clear it explicitly; every
    // other exit lands in a held state or coincides with the wrap to 0.
    assign prescale_run = (state_reg == ST_COOK) || (state_reg == ST_DONE);
    assign prescale_clr = ((state_reg == ST_COOK) && (stop || !door_closed || timer_zero)) ||
                          ((state_reg == ST_DONE) && (stop || !door_closed));

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clock  (clock),
        .clearn (clearn),
        .run    (prescale_run),
        .clr    (prescale_clr),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_reg        <= ST_IDLE;
            digit_cnt_reg    <= '0;
            beep_cnt_reg     <= '0;
            timer_loadn_reg  <= 1'b1;
            timer_data_reg   <= 4'd0;
            timer_enable_reg <= 1'b0;
            mag_on_reg       <= 1'b0;
            beep_reg         <= 1'b0;
            clr_pulse_reg    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            timer_loadn_reg  <= 1'b1;
            timer_enable_reg <= 1'b0;
            clr_pulse_reg    <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_ENTRY: begin
                    if ((state_reg == ST_ENTRY) && stop) begin
                        clr_pulse_reg <= 1'b1;
                        digit_cnt_reg <= '0;
                        state_reg     <= ST_IDLE;
                    end else if ((state_reg == ST_ENTRY) && start) begin
                        // A start request consumes the cycle: any key
                        // arriving with it is dropped even if the start
                        // itself is refused (door open or 0:00 loaded).
                        if (door_closed && !timer_zero) begin
                            state_reg  <= ST_COOK;
                            mag_on_reg <= 1'b1;
                        end
                    end else if (key_ok) begin
                        timer_data_reg  <= key_data;
                        timer_loadn_reg <= 1'b0;
                        digit_cnt_reg   <= digit_cnt_reg + 1'b1;
                        state_reg       <= ST_ENTRY;
                    end
                end

                ST_COOK: begin
                    if (stop || !door_closed) begin
                        state_reg  <= ST_PAUSE;
                        mag_on_reg <= 1'b0;
                    end else if (timer_zero) begin
                        state_reg    <= ST_DONE;
                        mag_on_reg   <= 1'b0;
                        beep_reg     <= 1'b1;
                        beep_cnt_reg <= '0;
                    end else if (tick) begin
                        // timer_zero is known low here, so the timer can
                        // never be asked to wrap from 0:00 to 9:59.
                        timer_enable_reg <= 1'b1;
                    end
                end

                ST_PAUSE: begin
                    if (stop) begin
                        clr_pulse_reg <= 1'b1;
                        digit_cnt_reg <= '0;
                        state_reg     <= ST_IDLE;
                    end else if (start && door_closed) begin
                        state_reg  <= ST_COOK;
                        mag_on_reg <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (stop || !door_closed) begin
                        beep_reg      <= 1'b0;
                        digit_cnt_reg <= '0;
                        state_reg     <= ST_IDLE;
                    end else if (tick) begin
                        if (beep_cnt_reg == BEEP_LAST) begin
                            beep_reg      <= 1'b0;
                            digit_cnt_reg <= '0;
                            state_reg     <= ST_IDLE;
                        end else begin
                            beep_cnt_reg <= beep_cnt_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg  <= ST_IDLE;
                    mag_on_reg <= 1'b0;
                    beep_reg   <= 1'b0;
                end
            endcase
        end
    end

    // The clear is combinational with reset so the timer is wiped the
    // moment clearn falls, not one clock later.
    assign timer_clearn = clearn & ~clr_pulse_reg;
    assign timer_loadn  = timer_loadn_reg;
    assign timer_data   = timer_data_reg;
    assign timer_enable = timer_enable_reg;
    assign mag_on       = mag_on_reg;
    assign beep         = beep_reg;
    assign state_o      = state_reg;

endmodule
